// File: rtl/pooling_stream_unit.sv
// Streaming pooling engine: reduces LANES x 2^beats_log2 signed samples to one max/min/avg/pass value.
// Optional feature macro POOL_ROUND_EN selects round-half-up averaging instead of floor.
module pooling_stream_unit #(
  parameter int unsigned DATA_W         = 16,
  parameter int unsigned LANES          = 4,
  parameter int unsigned MAX_BEATS_LOG2 = 3
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [LANES*DATA_W-1:0]              data_in,
  input  logic                                 valid_in,
  output logic                                 ready_in,
  output logic [DATA_W-1:0]                    data_out,
  output logic                                 valid_out,
  input  logic                                 ready_out,
  input  logic [1:0]                           pool_type,
  input  logic [$clog2(MAX_BEATS_LOG2+1)-1:0]  beats_log2,
  output logic                                 busy
);

  localparam int unsigned LogL  = $clog2(LANES);
  localparam int unsigned SumW  = DATA_W + LogL;
  localparam int unsigned AccW  = SumW + MAX_BEATS_LOG2;
  localparam int unsigned BlW   = $clog2(MAX_BEATS_LOG2 + 1);
  localparam int unsigned CntW  = (MAX_BEATS_LOG2 > 0) ? MAX_BEATS_LOG2 : 1;

  typedef enum logic [0:0] {StIdle, StAccum} state_e;

  state_e                   state_q, state_d;
  logic [1:0]               type_q, type_d;
  logic [BlW-1:0]           bl_q, bl_d;
  logic [CntW-1:0]          cnt_q, cnt_d;
  logic signed [DATA_W-1:0] max_q, max_d, min_q, min_d;
  logic signed [AccW-1:0]   sum_q, sum_d;
  logic [DATA_W-1:0]        out_q, out_d;
  logic                     valid_q, valid_d;

  logic signed [DATA_W-1:0] lane [LANES];
  logic signed [DATA_W-1:0] beat_max, beat_min;
  logic signed [SumW-1:0]   beat_sum;

  logic                     first, last, accept, take;
  logic [1:0]               eff_type;
  logic [BlW-1:0]           bl_clamped, eff_bl;
  logic [CntW:0]            last_idx;
  logic signed [DATA_W-1:0] new_max, new_min;
  logic signed [AccW-1:0]   sum_base, new_sum;
  logic [7:0]               shamt;
  logic signed [AccW:0]     avg_shr;
  logic [DATA_W-1:0]        result;

  // Per-beat lane reduction.
  always_comb begin
    for (int i = 0; i < int'(LANES); i++) begin
      lane[i] = data_in[i*DATA_W +: DATA_W];
    end
    beat_max = lane[0];
    beat_min = lane[0];
    beat_sum = SumW'(lane[0]);
    for (int i = 1; i < int'(LANES); i++) begin
      if (lane[i] > beat_max) beat_max = lane[i];
      if (lane[i] < beat_min) beat_min = lane[i];
      beat_sum = beat_sum + SumW'(lane[i]);
    end
  end

  always_comb begin
    bl_clamped = (beats_log2 > BlW'(MAX_BEATS_LOG2)) ? BlW'(MAX_BEATS_LOG2) : beats_log2;
    first      = (state_q == StIdle);
    // The beat that opens a window uses live config; later beats use the latched copy.
    eff_type   = first ? pool_type : type_q;
    eff_bl     = first ? bl_clamped : bl_q;
    last_idx   = ((CntW+1)'(1) << eff_bl) - (CntW+1)'(1);
    last       = ({1'b0, cnt_q} == last_idx);

    ready_in   = rst_n && !(valid_q && !ready_out);
    accept     = valid_in && ready_in;
    take       = valid_q && ready_out;

    new_max    = (first || beat_max > max_q) ? beat_max : max_q;
    new_min    = (first || beat_min < min_q) ? beat_min : min_q;
    sum_base   = first ? AccW'(0) : sum_q;
    new_sum    = sum_base + AccW'(beat_sum);

    shamt      = 8'(LogL) + 8'(eff_bl);
`ifdef POOL_ROUND_EN
    if (shamt == 8'd0) begin
      avg_shr = (AccW+1)'(new_sum);
    end else begin
      avg_shr = ((AccW+1)'(new_sum) + ((AccW+1)'(1) <<< (shamt - 8'd1))) >>> shamt;
    end
`else
    avg_shr = (AccW+1)'(new_sum) >>> shamt;
`endif

    unique case (eff_type)
      2'd0:    result = lane[0];
      2'd1:    result = new_max;
      2'd2:    result = DATA_W'(avg_shr);
      default: result = new_min;
    endcase
  end

  always_comb begin
    state_d = state_q;
    type_d  = type_q;
    bl_d    = bl_q;
    cnt_d   = cnt_q;
    max_d   = max_q;
    min_d   = min_q;
    sum_d   = sum_q;
    out_d   = out_q;
    valid_d = take ? 1'b0 : valid_q;

    if (accept) begin
      if (first) begin
        type_d = pool_type;
        bl_d   = bl_clamped;
      end
      if (last) begin
        out_d   = result;
        valid_d = 1'b1;
        state_d = StIdle;
        cnt_d   = '0;
        max_d   = '0;
        min_d   = '0;
        sum_d   = '0;
      end else begin
        state_d = StAccum;
        cnt_d   = cnt_q + CntW'(1);
        max_d   = new_max;
        min_d   = new_min;
        sum_d   = new_sum;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      type_q  <= 2'd0;
      bl_q    <= '0;
      cnt_q   <= '0;
      max_q   <= '0;
      min_q   <= '0;
      sum_q   <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      type_q  <= type_d;
      bl_q    <= bl_d;
      cnt_q   <= cnt_d;
      max_q   <= max_d;
      min_q   <= min_d;
      sum_q   <= sum_d;
      out_q   <= out_d;
      valid_q <= valid_d;
    end
  end

  assign data_out  = out_q;
  assign valid_out = valid_q;
  assign busy      = (state_q == StAccum);

endmodule

// File: doc/pooling_stream_unit.md
# pooling_stream_unit

Parametrised streaming pooling engine that reduces a window of `LANES × 2^beats_log2` signed samples to one output value. It supports max, min, average and pass-through modes and sustains one input beat per clock. It sits in the special-functions path after the activation stage, with valid/ready handshakes on both sides. It replaces the fixed 4-sample pooler with configurable data width, lane count and window depth, and adds a min mode and optional rounding.

## Interface

Parameters:
- `DATA_W`, 16, signed sample width
- `LANES`, 4, samples per input beat; must be a power of two, ≥1
- `MAX_BEATS_LOG2`, 3, largest supported `beats_log2` (window up to `LANES×8` samples)

Ports:
- `clk`  in  1  single clock; all logic on rising edge
- `rst_n`  in  1  synchronous, active-low reset
- `data_in`  in  `LANES*DATA_W`  packed lanes; lane i = bits `[i*DATA_W +: DATA_W]`, two's complement
- `valid_in`  in  1  input beat valid
- `ready_in`  out  1  input beat accepted when `valid_in && ready_in`
- `data_out`  out  `DATA_W`  pooled result, two's complement
- `valid_out`  out  1  result valid; held until taken
- `ready_out`  in  1  downstream accept
- `pool_type`  in  2  0 = pass-through (lane 0 of last beat), 1 = max, 2 = average, 3 = min
- `beats_log2`  in  `$clog2(MAX_BEATS_LOG2+1)`  window depth in beats = 2^beats_log2
- `busy`  out  1  high while a window is partially accumulated

## Operation

- FSM states:
  - IDLE: no beats of the current window accepted yet.
  - ACCUM: one or more beats accepted.
- First beat accepted in IDLE latches `pool_type` and `beats_log2` into shadow registers. Config changes mid-window are ignored until the next IDLE.
- A `beats_log2` value above `MAX_BEATS_LOG2` is clamped to `MAX_BEATS_LOG2` when latched.
- Per beat, a combinational tree reduces the lanes:
  - signed max and signed min
  - signed sum, `DATA_W+$clog2(LANES)` bits
- Accumulator registers:
  - Signed max and min: the first beat loads them, later beats compare against them.
  - Signed sum: width `ACC_W = DATA_W+$clog2(LANES)+MAX_BEATS_LOG2`, sign-extended; overflow is impossible.
- Beat counter counts accepted beats. When the accepted beat is beat `2^beats_log2 − 1`:
  - The result is written to the output register and `valid_out` is set next cycle.
  - Accumulators and counter clear; FSM returns to IDLE.
- With `beats_log2 = 0`, every beat is a complete window and the FSM stays in IDLE.
- Average: total shift `S = $clog2(LANES)+beats_log2`; the result is `sum >>> S` (arithmetic). The result always fits `DATA_W`, so no saturation is needed.
- `busy` = (state == ACCUM).

## Timing

- Latency: last beat accepted at edge t → `valid_out` high and `data_out` stable after edge t+1.
- Throughput: one beat per cycle while `ready_out` is high or no result is pending.
- `ready_in = rst_n && !(valid_out && !ready_out)`. This is combinational; the block stalls only when a result is pending and not taken.
- A result may be taken (`valid_out && ready_out`) in the same cycle a new window's last beat is accepted. The output register is then reloaded and `valid_out` stays high.
- A result taken with no new completion → `valid_out` low the next cycle.
- `data_out` holds its value while `valid_out && !ready_out`.
- Reset values (`rst_n` low at an edge):
  - `data_out` = 0, `valid_out` = 0, `busy` = 0, FSM in IDLE
  - accumulators and counter = 0
  - shadow config = pass-through, depth 0
  - `ready_in` = 0 while `rst_n` is low
- Reset mid-window discards the partial window; the beat presented in the reset cycle is not accepted.

## Configuration

- `POOL_ROUND_EN`:
  - Defined: average uses round-half-up, `(sum + 2^(S−1)) >>> S` for S > 0, unchanged for S = 0.
  - Undefined: average truncates toward −∞ (`sum >>> S`).
- Max, min and pass-through modes are unaffected by the macro.

## Test plan

- `DATA_W`=16, `LANES`=4, `beats_log2`=0, max, beat {3, −7, 12, 5} → `data_out`=12 one cycle after acceptance; the same beat in min mode → −7.
- Average, `beats_log2`=1, beats {1,2,3,4} and {5,6,7,9}: sum 37, S=3 → 4 without `POOL_ROUND_EN`, 5 with it. Beats {−1,−1,−1,−2} and {−1,−1,−1,−1}: sum −9 → −2 without the macro, −1 with it.
- Back-to-back windows at `beats_log2`=0 with `ready_out` tied high → one result per cycle, `ready_in` never drops.
- `ready_out` low for 5 cycles after a result → `ready_in` low and `data_out` stable throughout; the first beat after the take is accepted and no beat is lost.
- Change `pool_type` from max to min after beat 1 of a 4-beat window → the window reports max; the next window reports min.
- Assert `rst_n`=0 for 1 cycle after 2 of 4 beats → no output. The next 4 beats {8,8,8,8}×4 in average mode → 8.
